alu_sequencer: RTL and testbench

Multi-cycle control unit that sequences the shared 8-bit `alu` datapath for the project-4 CPU. It accepts one instruction at a time over a valid/ready handshake and drives the register-file read addresses and the ALU `OpCode`. It captures `AluOut`, `zero` and `carry`, then issues a single register-file write. It also owns the architectural zero/carry flag register and a retired-instruction counter.

---
 rtl/alu_sequencer_if.sv | 46 ++++
 rtl/alu_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bundles the instruction handshake, register-file, ALU and status
// signals of the ALU sequencer. The master modport is the sequencer
// side; the slave modport is the CPU datapath around it.
interface alu_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 8
);
  // Instruction handshake
  logic              InstrValid;
  logic              InstrReady;
  logic [3+3*AW-1:0] Instr;

  // Register-file read side and ALU control
  logic [AW-1:0]     RdAddrA;
  logic [AW-1:0]     RdAddrB;
  logic [2:0]        OpCode;

  // ALU results
  logic [DW-1:0]     AluOut;
  logic              zero;
  logic              carry;

  // Register-file write side
  logic [AW-1:0]     WrAddr;
  logic [DW-1:0]     WrData;
  logic              WrEn;

  // Architectural status
  logic              ZeroFlag;
  logic              CarryFlag;
  logic              Done;
  logic [CW-1:0]     InstrCount;

  modport master (
    input  InstrValid, Instr, AluOut, zero, carry,
    output InstrReady, RdAddrA, RdAddrB, OpCode,
           WrAddr, WrData, WrEn, ZeroFlag, CarryFlag, Done, InstrCount
  );

  modport slave (
    output InstrValid, Instr, AluOut, zero, carry,
    input  InstrReady, RdAddrA, RdAddrB, OpCode,
           WrAddr, WrData, WrEn, ZeroFlag, CarryFlag, Done, InstrCount
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the shared ALU datapath. One instruction is
// accepted in IDLE, its operands are read (READ), the ALU result and
// flags are captured (EXEC) and written back to the register file
// (WRITE). Also keeps the zero/carry flags and a retired-instruction count.
module alu_sequencer #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e        state_q,       state_d;
  logic [AW-1:0] rd_addr_a_q,   rd_addr_a_d;
  logic [AW-1:0] rd_addr_b_q,   rd_addr_b_d;
  logic [2:0]    op_code_q,     op_code_d;
  logic [AW-1:0] dest_q,        dest_d;
  logic [AW-1:0] wr_addr_q,     wr_addr_d;
  logic [DW-1:0] wr_data_q,     wr_data_d;
  logic          wr_en_q,       wr_en_d;
  logic          done_q,        done_d;
  logic          zero_flag_q,   zero_flag_d;
  logic          carry_flag_q,  carry_flag_d;
  logic [CW-1:0] instr_count_q, instr_count_d;

  logic accept;

  // Ready is a pure decode of the state so the producer sees it without a cycle of lag.
  assign bus.InstrReady = (state_q == IDLE);
  assign accept         = bus.InstrValid && (state_q == IDLE);

  // Next-state and next-output logic for the four-phase instruction sequence.
  always_comb begin
    // NOTE: every _d starts as its _q (or the idle value for the pulses) so no branch can infer a latch.
    state_d       = state_q;
    rd_addr_a_d   = rd_addr_a_q;
    rd_addr_b_d   = rd_addr_b_q;
    op_code_d     = op_code_q;
    dest_d        = dest_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_en_d       = 1'b0;
    done_d        = 1'b0;
    zero_flag_d   = zero_flag_q;
    carry_flag_d  = carry_flag_q;
    instr_count_d = instr_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Latching the fields here lets the addresses and opcode be valid for all of READ.
          op_code_d   = bus.Instr[3*AW+2 -: 3];
          dest_d      = bus.Instr[3*AW-1 -: AW];
          rd_addr_a_d = bus.Instr[2*AW-1 -: AW];
          rd_addr_b_d = bus.Instr[AW-1   -: AW];
          state_d     = READ;
        end
      end
      READ: begin
        // Register file read is registered; operands appear during EXEC.
        state_d = EXEC;
      end
      EXEC: begin
        wr_data_d    = bus.AluOut;
        zero_flag_d  = bus.zero;
        carry_flag_d = bus.carry;
        wr_addr_d    = dest_q;
        wr_en_d      = 1'b1;
        done_d       = 1'b1;
        state_d      = WRITE;
      end
      WRITE: begin
        instr_count_d = instr_count_q + CW'(1);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single state register for the FSM and all registered outputs; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rd_addr_a_q   <= '0;
      rd_addr_b_q   <= '0;
      op_code_q     <= '0;
      dest_q        <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      done_q        <= 1'b0;
      zero_flag_q   <= 1'b0;
      carry_flag_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q       <= state_d;
      rd_addr_a_q   <= rd_addr_a_d;
      rd_addr_b_q   <= rd_addr_b_d;
      op_code_q     <= op_code_d;
      dest_q        <= dest_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
      done_q        <= done_d;
      zero_flag_q   <= zero_flag_d;
      carry_flag_q  <= carry_flag_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.RdAddrA    = rd_addr_a_q;
  assign bus.RdAddrB    = rd_addr_b_q;
  assign bus.OpCode     = op_code_q;
  assign bus.WrAddr     = wr_addr_q;
  assign bus.WrData     = wr_data_q;
  assign bus.WrEn       = wr_en_q;
  assign bus.Done       = done_q;
  assign bus.ZeroFlag   = zero_flag_q;
  assign bus.CarryFlag  = carry_flag_q;
  assign bus.InstrCount = instr_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the register file (registered read)
// and the combinational ALU around the sequencer, predicts each
// write-back with an independent reference function and compares it
// through a scoreboard when the write strobe appears.
module tb_alu_sequencer;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          zf;
    logic          cf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  alu_sequencer #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int done_count = 0;
  int acc_total = 0;
  int ready_low_run = 0;
  int last_low_run = 0;
  logic [DW-1:0] last_wr_data = '0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [CW-1:0] exp_count = '0;

  exp_t sb_q[$];
  int   acc_q[$];
  int   acc_hist[$];

  logic [DW-1:0] regs [8];
  logic [DW-1:0] ref_regs [8];
  logic [DW-1:0] rd_a, rd_b;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [DW:0]   alu_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference of the ALU semantics used by the project CPU.
  function automatic exp_t ref_op(input logic [2:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [AW-1:0] d);
    exp_t e;
    int ia, ib, r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    c  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 255); end
      3'd1: begin r = (ia - ib + 256) % 256; c = (ia < ib); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 255 - ia;
      3'd6: r = ia;
      default: r = ib;
    endcase
    e.addr = d;
    e.data = DW'(r % 256);
    e.zf   = ((r % 256) == 0);
    e.cf   = c;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Register file with registered read ports and a bench load port.
  always @(posedge clk) begin
    rd_a <= regs[bus.RdAddrA];
    rd_b <= regs[bus.RdAddrB];
    if (bus.WrEn) regs[bus.WrAddr] <= bus.WrData;
    if (load_en) regs[load_addr] <= load_data;
  end

  // Combinational ALU.
  always_comb begin
    alu_t = '0;
    case (bus.OpCode)
      3'b000: alu_t = {1'b0, rd_a} + {1'b0, rd_b};
      3'b001: alu_t = {1'b0, rd_a} - {1'b0, rd_b};
      3'b010: alu_t = {1'b0, rd_a & rd_b};
      3'b011: alu_t = {1'b0, rd_a | rd_b};
      3'b100: alu_t = {1'b0, rd_a ^ rd_b};
      3'b101: alu_t = {1'b0, ~rd_a};
      3'b110: alu_t = {1'b0, rd_a};
      default: alu_t = {1'b0, rd_b};
    endcase
    bus.AluOut = alu_t[DW-1:0];
    bus.carry  = alu_t[DW];
    bus.zero   = (alu_t[DW-1:0] == '0);
  end

  // Monitor: records accepts and compares each write-back against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
      acc_q.delete();
      ready_low_run = 0;
    end else begin
      if (bus.InstrValid && bus.InstrReady) begin
        acc_q.push_back(cyc + 1);
        acc_hist.push_back(cyc + 1);
        acc_total++;
      end
      if (!bus.InstrReady) ready_low_run++;
      else begin
        if (ready_low_run > 0) last_low_run = ready_low_run;
        ready_low_run = 0;
      end
      if (bus.WrEn || bus.Done) begin
        wr_count++;
        if (bus.Done) done_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_write", {30'd0, bus.WrEn, bus.Done}, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = sb_q.pop_front();
          a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
          check("wr_en",      bus.WrEn,      1);
          check("done",       bus.Done,      1);
          check("wr_addr",    bus.WrAddr,    e.addr);
          check("wr_data",    bus.WrData,    e.data);
          check("zero_flag",  bus.ZeroFlag,  e.zf);
          check("carry_flag", bus.CarryFlag, e.cf);
          check("wr_latency", cyc,           a + 2);
          last_wr_data = bus.WrData;
          last_wr_addr = bus.WrAddr;
        end
      end
    end
  end

  task automatic set_reg(input logic [AW-1:0] i, input logic [DW-1:0] v);
    load_addr = i;
    load_data = v;
    load_en   = 1'b1;
    @(posedge clk); #1;
    load_en   = 1'b0;
    ref_regs[i] = v;
  endtask

  // Pushes the prediction, presents the instruction and waits for its accept edge.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] d, input logic [AW-1:0] sa,
                       input logic [AW-1:0] sb, input bit hold);
    exp_t e;
    int   start, k;
    e = ref_op(op, ref_regs[sa], ref_regs[sb], d);
    ref_regs[d] = e.data;
    sb_q.push_back(e);
    exp_count++;
    bus.Instr      = {op, d, sa, sb};
    bus.InstrValid = 1'b1;
    start = acc_total;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (acc_total == start && k < 20);
    if (acc_total == start) check("accept_timeout", acc_total, start + 1);
    if (!hold) bus.InstrValid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_count < target && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_reached", done_count, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, h0;
    logic [DW-1:0] pre;
    logic [DW-1:0] saved;

    bus.InstrValid = 1'b0;
    bus.Instr      = '0;

    // Reset held three cycles, then released.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_ready",    bus.InstrReady, 1);
    check("rst_rdaddr_a", bus.RdAddrA,    0);
    check("rst_rdaddr_b", bus.RdAddrB,    0);
    check("rst_opcode",   bus.OpCode,     0);
    check("rst_wr_addr",  bus.WrAddr,     0);
    check("rst_wr_data",  bus.WrData,     0);
    check("rst_wr_en",    bus.WrEn,       0);
    check("rst_done",     bus.Done,       0);
    check("rst_zero",     bus.ZeroFlag,   0);
    check("rst_carry",    bus.CarryFlag,  0);
    check("rst_count",    bus.InstrCount, 0);
    w0 = wr_count;
    repeat (10) @(posedge clk);
    #1 check("idle_no_write", wr_count, w0);

    for (int i = 0; i < 8; i++) set_reg(AW'(i), DW'($urandom_range(0, 255)));
    set_reg(3'd0, 8'h80);
    set_reg(3'd1, 8'h80);
    set_reg(3'd3, 8'h05);
    set_reg(3'd4, 8'h07);

    // ADD overflow: 0x80 + 0x80 into r2.
    d0 = done_count;
    issue(3'b000, 3'd2, 3'd0, 3'd1, 1'b0);
    wait_done(d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    check("add_data",   last_wr_data,   8'h00);
    check("add_addr",   last_wr_addr,   3'd2);
    check("add_zero",   bus.ZeroFlag,   1);
    check("add_carry",  bus.CarryFlag,  1);
    check("add_count",  bus.InstrCount, 1);
    check("add_pulses", done_count - d0, 1);
    check("add_regfile", regs[2],       8'h00);

    // SUB with borrow: 5 - 7 into r5.
    d0 = done_count;
    issue(3'b001, 3'd5, 3'd3, 3'd4, 1'b0);
    wait_done(d0 + 1);
    #1;
    check("sub_data",  last_wr_data,  8'hFE);
    check("sub_addr",  last_wr_addr,  3'd5);
    check("sub_carry", bus.CarryFlag, 1);
    check("sub_zero",  bus.ZeroFlag,  0);

    // Back-to-back AND, OR, XOR with InstrValid held high.
    set_reg(3'd5, DW'($urandom_range(0, 255)));
    set_reg(3'd6, DW'($urandom_range(0, 255)));
    set_reg(3'd7, DW'($urandom_range(0, 255)));
    d0 = done_count;
    h0 = acc_hist.size();
    issue(3'b010, 3'd5, 3'd6, 3'd7, 1'b1);
    issue(3'b011, 3'd6, 3'd5, 3'd7, 1'b1);
    issue(3'b100, 3'd7, 3'd5, 3'd6, 1'b1);
    bus.InstrValid = 1'b0;
    wait_done(d0 + 3);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_gap_1",     acc_hist[h0+1] - acc_hist[h0],   4);
    check("b2b_gap_2",     acc_hist[h0+2] - acc_hist[h0+1], 4);
    check("b2b_ready_low", last_low_run,                    3);
    check("b2b_count",     bus.InstrCount,                  exp_count);
    check("b2b_reg7",      regs[7],                         ref_regs[7]);

    // Set both flags, then abort an ADD with reset during EXEC.
    d0 = done_count;
    issue(3'b000, 3'd2, 3'd0, 3'd1, 1'b0);
    wait_done(d0 + 1);
    #1 check("pre_abort_carry", bus.CarryFlag, 1);
    pre   = regs[3];
    saved = ref_regs[3];
    w0    = wr_count;
    issue(3'b000, 3'd3, 3'd0, 3'd1, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    ref_regs[3] = saved;
    exp_count   = '0;
    #1;
    check("abort_wr_en", bus.WrEn,       0);
    check("abort_zero",  bus.ZeroFlag,   0);
    check("abort_carry", bus.CarryFlag,  0);
    check("abort_count", bus.InstrCount, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_write", wr_count,       w0);
    check("abort_target",   regs[3],        pre);
    check("abort_ready",    bus.InstrReady, 1);
    check("abort_count2",   bus.InstrCount, 0);

    // Counter wrap over 256 retired instructions.
    d0 = done_count;
    for (int i = 0; i < 256; i++) begin
      issue(3'($urandom_range(0, 7)), AW'($urandom_range(2, 7)),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'b0);
      wait_done(d0 + i + 1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("wrap_count",  bus.InstrCount,  0);
    check("wrap_pulses", done_count - d0, 256);
    check("wrap_sb_empty", sb_q.size(),   0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
